// File: rtl/apb_cmd_sequencer.sv
// APB command front-end: queues host read/write commands and issues them one at a time
// to the APB single-slave subsystem, returning one response per command.
package apb_pkg;
  localparam int SLV_ADDR_WIDTH = 2;
  localparam int ADDR_WIDTH     = 8;
  localparam int DATA_WIDTH     = 8;
endpackage

module apb_cmd_sequencer
  import apb_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_wr,
  input  logic [SLV_ADDR_WIDTH-1:0] cmd_slv,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [SLV_ADDR_WIDTH-1:0] slv_addr_o,
  output logic [ADDR_WIDTH-1:0]     addr_o,
  output logic [DATA_WIDTH-1:0]     data_o,
  output logic                      wr_o,
  output logic                      newd_o,
  input  logic                      done_i,
  input  logic [DATA_WIDTH-1:0]     dataout_i,
  input  logic                      slverr_i,
  output logic                      busy_o,
  output logic [$clog2(DEPTH):0]    level_o
);

  // state | meaning
  // IDLE  | no transfer in flight, no response held
  // ISSUE | one-cycle newd pulse, head popped
  // WAIT  | waiting for done_i or timeout
  // RESP  | response held until rsp_ready
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef struct packed {
    logic                      wr;
    logic [SLV_ADDR_WIDTH-1:0] slv;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     wdata;
  } cmd_t;

  state_t                    state_q, state_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]             level_q, level_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [SLV_ADDR_WIDTH-1:0] slv_q, slv_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      wr_q, wr_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      tmo_q, tmo_d;

  cmd_t mem_q [DEPTH];
  cmd_t cmd_in;
  cmd_t head;
  logic push;
  logic pop;

  assign cmd_ready = (level_q < LW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == ISSUE);
  assign cmd_in    = '{wr: cmd_wr, slv: cmd_slv, addr: cmd_addr, wdata: cmd_wdata};
  assign head      = mem_q[rd_ptr_q];

  // Storage needs no reset: level_q alone decides which entries are meaningful.
  always_ff @(posedge pclk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slv_d   = slv_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          state_d = ISSUE;
          slv_d   = head.slv;
          addr_d  = head.addr;
          data_d  = head.wdata;
          wr_d    = head.wr;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // done_i takes priority over an expiring timer in the same cycle
        if (done_i) begin
          state_d = RESP;
          rdata_d = wr_q ? '0 : dataout_i;
          err_d   = slverr_i;
          tmo_d   = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      slv_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      slv_q    <= slv_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;
  assign slv_addr_o  = slv_q;
  assign addr_o      = addr_q;
  assign data_o      = data_q;
  assign wr_o        = wr_q;
  assign newd_o      = (state_q == ISSUE);
  assign busy_o      = (state_q != IDLE);
  assign level_o     = level_q;

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Directed self-checking bench for apb_cmd_sequencer (DEPTH=4, TIMEOUT=16).
module tb_apb_cmd_sequencer;
  import apb_pkg::*;

  logic                      pclk = 1'b0;
  logic                      preset;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_wr;
  logic [SLV_ADDR_WIDTH-1:0] cmd_slv;
  logic [ADDR_WIDTH-1:0]     cmd_addr;
  logic [DATA_WIDTH-1:0]     cmd_wdata;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic                      rsp_err;
  logic                      rsp_timeout;
  logic [SLV_ADDR_WIDTH-1:0] slv_addr_o;
  logic [ADDR_WIDTH-1:0]     addr_o;
  logic [DATA_WIDTH-1:0]     data_o;
  logic                      wr_o;
  logic                      newd_o;
  logic                      done_i;
  logic [DATA_WIDTH-1:0]     dataout_i;
  logic                      slverr_i;
  logic                      busy_o;
  logic [2:0]                level_o;

  int n_checks = 0;
  int n_fail   = 0;

  apb_cmd_sequencer #(.DEPTH(4), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_slv(cmd_slv), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .slv_addr_o(slv_addr_o), .addr_o(addr_o), .data_o(data_o), .wr_o(wr_o),
    .newd_o(newd_o), .done_i(done_i), .dataout_i(dataout_i), .slverr_i(slverr_i),
    .busy_o(busy_o), .level_o(level_o)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_cmd(input logic wr, input logic [7:0] slv, input logic [7:0] addr,
                         input logic [7:0] wdata);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_slv   = slv[SLV_ADDR_WIDTH-1:0];
    cmd_addr  = addr;
    cmd_wdata = wdata;
  endtask

  task automatic wait_newd(input string tag);
    int n = 0;
    while (!newd_o && n < 8) begin
      tick();
      n++;
    end
    check(tag, {31'd0, newd_o}, 32'd1);
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check(tag, {31'd0, rsp_valid}, 32'd0);
  endtask

  int n_newd;
  int n_rsp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_slv = '0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b0; done_i = 1'b0; dataout_i = '0; slverr_i = 1'b0;
    tick(); tick();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_newd",      {31'd0, newd_o}, 32'd0);
    check("rst_busy",      {31'd0, busy_o}, 32'd0);
    check("rst_level",     {29'd0, level_o}, 32'd0);
    preset = 1'b0;
    tick();

    // single write
    set_cmd(1'b1, 8'd1, 8'h04, 8'hA5);
    tick();
    cmd_valid = 1'b0;
    check("wr_level1", {29'd0, level_o}, 32'd1);
    check("wr_newd_early", {31'd0, newd_o}, 32'd0);
    tick();
    check("wr_newd", {31'd0, newd_o}, 32'd1);
    check("wr_addr", {24'd0, addr_o}, 32'h04);
    check("wr_data", {24'd0, data_o}, 32'hA5);
    check("wr_wr", {31'd0, wr_o}, 32'd1);
    check("wr_slv", {30'd0, slv_addr_o}, 32'd1);
    tick();
    check("wr_newd_once", {31'd0, newd_o}, 32'd0);
    check("wr_level0", {29'd0, level_o}, 32'd0);
    done_i = 1'b1; dataout_i = 8'hFF;
    tick();
    done_i = 1'b0;
    check("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("wr_rsp_rdata", {24'd0, rsp_rdata}, 32'h00);
    check("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("wr_rsp_tmo", {31'd0, rsp_timeout}, 32'd0);
    check("wr_data_stable", {24'd0, data_o}, 32'hA5);
    handshake("wr_rsp_clear");
    check("wr_idle", {31'd0, busy_o}, 32'd0);

    // single read
    set_cmd(1'b0, 8'd2, 8'h08, 8'h00);
    tick();
    cmd_valid = 1'b0;
    tick();
    check("rd_newd", {31'd0, newd_o}, 32'd1);
    check("rd_addr", {24'd0, addr_o}, 32'h08);
    check("rd_wr", {31'd0, wr_o}, 32'd0);
    tick();
    done_i = 1'b1; dataout_i = 8'h3C; slverr_i = 1'b0;
    tick();
    done_i = 1'b0;
    check("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd_rsp_rdata", {24'd0, rsp_rdata}, 32'h3C);
    check("rd_rsp_err", {31'd0, rsp_err}, 32'd0);
    handshake("rd_rsp_clear");

    // slave error with a second command queued behind it
    set_cmd(1'b0, 8'd0, 8'h10, 8'h00);
    tick();
    set_cmd(1'b0, 8'd0, 8'h14, 8'h00);
    tick();
    cmd_valid = 1'b0;
    check("se_newd_a", {31'd0, newd_o}, 32'd1);
    check("se_addr_a", {24'd0, addr_o}, 32'h10);
    tick();
    done_i = 1'b1; dataout_i = 8'h55; slverr_i = 1'b1;
    tick();
    done_i = 1'b0; slverr_i = 1'b0;
    check("se_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("se_rsp_err", {31'd0, rsp_err}, 32'd1);
    check("se_rsp_tmo", {31'd0, rsp_timeout}, 32'd0);
    check("se_rsp_rdata", {24'd0, rsp_rdata}, 32'h55);
    handshake("se_rsp_clear");
    tick();
    check("se_newd_b", {31'd0, newd_o}, 32'd1);
    check("se_addr_b", {24'd0, addr_o}, 32'h14);
    tick();
    done_i = 1'b1; dataout_i = 8'h66;
    tick();
    done_i = 1'b0;
    check("se_b_rdata", {24'd0, rsp_rdata}, 32'h66);
    check("se_b_err", {31'd0, rsp_err}, 32'd0);
    handshake("se_b_clear");

    // timeout, then a late done_i
    set_cmd(1'b0, 8'd3, 8'h20, 8'h00);
    tick();
    cmd_valid = 1'b0;
    tick();
    check("to_newd", {31'd0, newd_o}, 32'd1);
    tick();
    for (int i = 0; i < 15; i++) tick();
    check("to_not_yet", {31'd0, rsp_valid}, 32'd0);
    check("to_busy", {31'd0, busy_o}, 32'd1);
    tick();
    check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    check("to_rsp_tmo", {31'd0, rsp_timeout}, 32'd1);
    check("to_rsp_rdata", {24'd0, rsp_rdata}, 32'h00);
    done_i = 1'b1; dataout_i = 8'h77;
    tick();
    done_i = 1'b0;
    check("to_late_valid", {31'd0, rsp_valid}, 32'd1);
    check("to_late_tmo", {31'd0, rsp_timeout}, 32'd1);
    check("to_late_rdata", {24'd0, rsp_rdata}, 32'h00);
    handshake("to_rsp_clear");
    tick();
    check("to_idle_after", {31'd0, busy_o}, 32'd0);

    // backpressure: five reads, rsp_ready held low
    for (int i = 0; i < 5; i++) begin
      set_cmd(1'b0, 8'd0, 8'h30 + 8'(i), 8'h00);
      check($sformatf("bp_ready_%0d", i), {31'd0, cmd_ready}, 32'd1);
      tick();
    end
    cmd_valid = 1'b0;
    check("bp_full_level", {29'd0, level_o}, 32'd4);
    check("bp_full_ready", {31'd0, cmd_ready}, 32'd0);
    done_i = 1'b1; dataout_i = 8'hC0;
    tick();
    done_i = 1'b0;
    check("bp_rsp0_valid", {31'd0, rsp_valid}, 32'd1);
    n_newd = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (newd_o) n_newd++;
    end
    check("bp_no_newd", n_newd, 32'd0);
    check("bp_rsp0_held", {31'd0, rsp_valid}, 32'd1);
    check("bp_rsp0_rdata", {24'd0, rsp_rdata}, 32'hC0);
    rsp_ready = 1'b1;
    tick();
    for (int i = 1; i < 5; i++) begin
      wait_newd($sformatf("bp_newd_%0d", i));
      check($sformatf("bp_addr_%0d", i), {24'd0, addr_o}, 32'h30 + i);
      tick();
      done_i = 1'b1; dataout_i = 8'hC0 + 8'(i);
      tick();
      done_i = 1'b0;
      check($sformatf("bp_rsp_valid_%0d", i), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("bp_rsp_rdata_%0d", i), {24'd0, rsp_rdata}, 32'hC0 + i);
      tick();
    end
    rsp_ready = 1'b0;
    check("bp_drained_level", {29'd0, level_o}, 32'd0);
    check("bp_drained_busy", {31'd0, busy_o}, 32'd0);

    // reset during WAIT with two commands still queued
    for (int i = 0; i < 3; i++) begin
      set_cmd(1'b1, 8'd2, 8'h40 + 8'(i), 8'h90 + 8'(i));
      tick();
    end
    cmd_valid = 1'b0;
    check("rst_mid_level", {29'd0, level_o}, 32'd2);
    check("rst_mid_busy", {31'd0, busy_o}, 32'd1);
    check("rst_mid_addr", {24'd0, addr_o}, 32'h40);
    #2 preset = 1'b1;
    #1;
    check("rstm_level", {29'd0, level_o}, 32'd0);
    check("rstm_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rstm_busy", {31'd0, busy_o}, 32'd0);
    check("rstm_addr", {24'd0, addr_o}, 32'd0);
    check("rstm_data", {24'd0, data_o}, 32'd0);
    check("rstm_slv", {30'd0, slv_addr_o}, 32'd0);
    check("rstm_wr", {31'd0, wr_o}, 32'd0);
    check("rstm_newd", {31'd0, newd_o}, 32'd0);
    check("rstm_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    #2 preset = 1'b0;
    rsp_ready = 1'b1;
    n_newd = 0;
    n_rsp  = 0;
    for (int i = 0; i < 30; i++) begin
      done_i = (i == 3);
      tick();
      if (newd_o) n_newd++;
      if (rsp_valid) n_rsp++;
    end
    done_i = 1'b0;
    rsp_ready = 1'b0;
    check("rstm_no_newd", n_newd, 32'd0);
    check("rstm_no_rsp", n_rsp, 32'd0);
    check("rstm_level_after", {29'd0, level_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_cmd_sequencer.md
# apb_cmd_sequencer

Command front-end that sits directly upstream of the APB single-slave subsystem and drives its `slv_addr_in`/`addrin`/`datain`/`wr`/`newd` inputs. It buffers host read/write commands in a small FIFO and issues them one at a time. It waits for completion or a timeout, then returns one response per command (read data plus error flags) over a valid/ready channel. Only one transfer is outstanding downstream at any time.

## Interface

Parameters:

- `DEPTH`, 4: command FIFO entries; power of two, ≥ 2.
- `TIMEOUT`, 16: maximum cycles spent in WAIT before abort; ≥ 2.
- Widths come from `apb_pkg`: `SLV_ADDR_WIDTH`, `ADDR_WIDTH`, `DATA_WIDTH`.

Ports:

- `pclk`  in  1  clock; all logic on rising edge.
- `preset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  FIFO can accept a command (`!full`).
- `cmd_wr`  in  1  1 = write, 0 = read.
- `cmd_slv`  in  SLV_ADDR_WIDTH  target slave select.
- `cmd_addr`  in  ADDR_WIDTH  register address.
- `cmd_wdata`  in  DATA_WIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  host consumes response.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- `rsp_err`  out  1  slave error or timeout.
- `rsp_timeout`  out  1  transfer aborted by timeout.
- `slv_addr_o`  out  SLV_ADDR_WIDTH  to subsystem `slv_addr_in`.
- `addr_o`  out  ADDR_WIDTH  to `addrin`.
- `data_o`  out  DATA_WIDTH  to `datain`.
- `wr_o`  out  1  to `wr`.
- `newd_o`  out  1  to `newd`; one-cycle start pulse.
- `done_i`  in  1  downstream transfer complete (single-cycle strobe).
- `dataout_i`  in  DATA_WIDTH  from subsystem `dataout`.
- `slverr_i`  in  1  from subsystem `slverr_o`; valid with `done_i`.
- `busy_o`  out  1  state ≠ IDLE.
- `level_o`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation

- **FIFO**
  - Push on `cmd_valid && cmd_ready`. Pop only in ISSUE.
  - `cmd_ready = (level < DEPTH)`, combinational from registered level.
  - A push and a pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo DEPTH.
- **FSM states**
  - **IDLE**
    - Goes to ISSUE when FIFO is non-empty and `rsp_valid` = 0.
  - **ISSUE** (exactly 1 cycle)
    - `newd_o` = 1.
    - Head fields are registered onto `slv_addr_o`/`addr_o`/`data_o`/`wr_o` on the IDLE→ISSUE edge.
    - FIFO pops; next state WAIT; wait counter cleared.
    - `done_i` is ignored in this state.
  - **WAIT**
    - On `done_i`: capture `rsp_rdata = wr_o ? 0 : dataout_i`, `rsp_err = slverr_i`, `rsp_timeout = 0`; go to RESP.
    - Otherwise, if counter == TIMEOUT-1: `rsp_rdata = 0`, `rsp_err = 1`, `rsp_timeout = 1`; go to RESP.
    - Otherwise counter increments.
    - If `done_i` arrives in the same cycle as counter == TIMEOUT-1, `done_i` wins.
  - **RESP**
    - `rsp_valid` = 1 and response fields held stable.
    - On `rsp_ready`: clear `rsp_valid`, go to IDLE.
- **Downstream fields** stay stable from ISSUE until the next ISSUE.
- **Reset** (async, immediate):
  - State IDLE, FIFO empty, `level_o` = 0.
  - All outputs 0 except `cmd_ready` = 1.
  - A reset mid-WAIT discards the in-flight command and all queued commands. No response is produced.

## Timing

- Command accepted at edge k into an empty FIFO while idle:
  - ISSUE entered at edge k+1.
  - `newd_o` high for the single cycle between edges k+1 and k+2.
- `done_i` is first sampled at edge k+3, the first WAIT cycle.
- `done_i` high at edge j → `rsp_valid` high after edge j.
- Response handshake at edge r → IDLE after r. The next ISSUE starts at edge r+1 if the FIFO is non-empty.
  - Minimum issue spacing is therefore 4 cycles when `done_i` returns in the first WAIT cycle and `rsp_ready` is tied high.
- Timeout fires at the TIMEOUT-th WAIT edge without `done_i`. `rsp_valid` rises after that edge.
- A late `done_i` arriving in RESP or IDLE is ignored.
- `busy_o` and `level_o` are registered; no combinational path from host inputs to downstream outputs.

## Test plan

- **Single write:** push wr=1, slv=1, addr=0x04, wdata=0xA5. Expect:
  - `newd_o` exactly one cycle, with `addr_o` = 0x04 and `data_o` = 0xA5.
  - `done_i` two cycles later → response rdata=0, err=0, timeout=0.
- **Single read:** push wr=0, addr=0x08; `done_i` with `dataout_i` = 0x3C, `slverr_i` = 0. Expect rsp_rdata=0x3C, err=0.
- **Slave error:** read with `slverr_i` = 1 on `done_i`. Expect err=1, timeout=0; next queued command still issued.
- **Timeout:** read, `done_i` never asserted, TIMEOUT=16. Expect:
  - `rsp_valid` 16 WAIT cycles after ISSUE, with err=1, timeout=1, rdata=0.
  - A late `done_i` one cycle later changes nothing.
- **Backpressure, DEPTH=4:**
  - Push 5 commands with `rsp_ready` = 0. Expect `cmd_ready` low after the FIFO holds 4 (one already issued).
  - No second `newd_o` until the first response is consumed.
  - Release `rsp_ready`: all 5 responses return in order.
- **Reset mid-operation:** assert `preset` during WAIT with 2 commands queued. Expect:
  - All outputs 0 immediately, `level_o` = 0, `cmd_ready` = 1.
  - After release, no response for the discarded commands.
